// File: rtl/shared_dram_pkg.sv
// Shared definitions for shared_dram: FSM encoding, default widths, core limit
// and the modulo helper used by the round-robin search.
package shared_dram_pkg;

  typedef enum logic [1:0] {
    SD_IDLE   = 2'd0,
    SD_ACCESS = 2'd1,
    SD_RESP   = 2'd2
  } sd_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int MAX_CORES  = 8;

  function automatic int unsigned sd_wrap(input int unsigned v, input int unsigned n);
    return v % n;
  endfunction

endpackage

// File: rtl/shared_dram_if.sv
// Request/response bundle between the core load/store units and shared_dram.
// Per-core fields are flattened: core i sits at [i*W +: W].
interface shared_dram_if
  import shared_dram_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W
);

  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0]        ack;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;
  logic                        err;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, busy, err
  );

endinterface

// File: rtl/shared_dram_rr_arb.sv
// Round-robin arbiter: combinational grant searching upward from the pointer,
// pointer moves to grant+1 whenever the grant is taken.
module shared_dram_rr_arb
  import shared_dram_pkg::*;
#(
  parameter int NUM_CORES = 4,
  localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 take,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!gnt_valid && req[IDX_W'(sd_wrap(32'(ptr) + i, NUM_CORES))]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(sd_wrap(32'(ptr) + i, NUM_CORES));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/shared_dram.sv
// Multi-port shared data RAM: round-robin arbitrated, IDLE/ACCESS/RESP FSM.
// Optional SHARED_DRAM_ADDR_CHECK_EN adds an out-of-range check driving err.
module shared_dram
  import shared_dram_pkg::*;
#(
  parameter int    NUM_CORES = 4,
  parameter int    DATA_W    = DEF_DATA_W,
  parameter int    ADDR_W    = DEF_ADDR_W,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input logic          clk,
  input logic          rst_n,
  shared_dram_if.slave bus
);

  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (NUM_CORES < 2 || NUM_CORES > MAX_CORES) begin : g_bad_cfg
    $error("shared_dram: NUM_CORES out of range");
  end

  sd_state_e         state, state_next;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic              take;

  logic [IDX_W-1:0]  lat_idx;
  logic              lat_we;
  logic [MEM_AW-1:0] lat_maddr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              lat_oor;

  logic [DATA_W-1:0] mem [DEPTH];

  shared_dram_rr_arb #(
    .NUM_CORES(NUM_CORES)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req),
    .take     (take),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SD_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    bus.ack    = '0;
    bus.busy   = 1'b0;
    case (state)
      SD_IDLE: begin
        if (gnt_valid) begin
          take       = 1'b1;
          state_next = SD_ACCESS;
        end
      end
      SD_ACCESS: begin
        bus.busy   = 1'b1;
        state_next = SD_RESP;
      end
      SD_RESP: begin
        bus.busy         = 1'b1;
        bus.ack[lat_idx] = 1'b1;
        state_next       = SD_IDLE;
      end
      default: state_next = SD_IDLE;
    endcase
  end

  // Only the array-index bits of the address are kept; aliasing falls out of this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_maddr <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (take) begin
        lat_idx   <= gnt_idx;
        lat_we    <= bus.we[gnt_idx];
        lat_maddr <= bus.addr[gnt_idx*ADDR_W +: MEM_AW];
        lat_wdata <= bus.wdata[gnt_idx*DATA_W +: DATA_W];
      end
      if (state == SD_ACCESS && !lat_we) begin
        rdata_q <= lat_oor ? '0 : mem[lat_maddr];
      end
    end
  end

  // Array has no reset; an aborted transaction never reaches ACCESS with reset low.
  always_ff @(posedge clk) begin
    if (state == SD_ACCESS && lat_we && !lat_oor) begin
      mem[lat_maddr] <= lat_wdata;
    end
  end

  assign bus.rdata = rdata_q;

`ifdef SHARED_DRAM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_oor <= 1'b0;
    end else if (take) begin
      lat_oor <= ({1'b0, bus.addr[gnt_idx*ADDR_W +: ADDR_W]} >= (ADDR_W+1)'(DEPTH));
    end
  end

  assign bus.err = (state == SD_RESP) && lat_oor;
`else
  assign lat_oor = 1'b0;
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_shared_dram.sv
// Directed bench for shared_dram: single/write-read, aliasing or range check,
// mid-transaction reset, contention ordering and round-robin fairness.
module tb_shared_dram;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shared_dram_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus ();

  shared_dram #(
    .NUM_CORES(NC),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (1024),
    .INIT_FILE("")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          lat;
  logic [15:0] rd;
  logic        er;
  logic        bz;
  int          got_core [8];
  int          got_cyc  [8];
  int          got_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single transaction from one core; lat counts negedges from request to ack (-1 = timeout).
  task automatic xact(input int core, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int l, output logic [15:0] r, output logic e, output logic b);
    @(negedge clk);
    bus.we[core]             = w;
    bus.addr[core*AW +: AW]  = a;
    bus.wdata[core*DW +: DW] = d;
    bus.req[core]            = 1'b1;
    l = -1; r = '0; e = 1'b0; b = 1'b0;
    for (int c = 1; c <= 10 && l < 0; c++) begin
      @(negedge clk);
      if (c == 1) b = bus.busy;
      if (bus.ack[core]) begin
        l = c;
        r = bus.rdata;
        e = bus.err;
      end
    end
    bus.req[core] = 1'b0;
  endtask

  // Raise mask requests; cores in hold keep requesting after their ack.
  task automatic run_round(input logic [3:0] mask, input logic [3:0] hold, input int want, input int budget);
    logic [3:0] prev;
    int         idx;
    prev    = '0;
    got_n   = 0;
    bus.req = bus.req | mask;
    for (int c = 1; c <= budget && got_n < want; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        check_eq("ack_excl", {30'd0, prev == 4'd0, $onehot(bus.ack)}, 32'd3);
        idx = -1;
        for (int k = 0; k < NC; k++) if (bus.ack[k]) idx = k;
        got_core[got_n] = idx;
        got_cyc[got_n]  = c;
        got_n++;
        bus.req = bus.req & ~(bus.ack & ~hold);
      end
      prev = bus.ack;
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    do_reset();

    check_eq("rst_ack",   32'(bus.ack),   32'd0);
    check_eq("rst_busy",  32'(bus.busy),  32'd0);
    check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
    check_eq("rst_err",   32'(bus.err),   32'd0);

    xact(1, 1'b1, 16'd5, 16'h00AB, lat, rd, er, bz);
    check_eq("pre_lat", 32'(lat), 32'd2);

    xact(0, 1'b0, 16'd5, 16'h0000, lat, rd, er, bz);
    check_eq("rd_lat",  32'(lat), 32'd2);
    check_eq("rd_data", 32'(rd),  32'h00AB);
    check_eq("rd_busy", 32'(bz),  32'd1);
    check_eq("rd_err",  32'(er),  32'd0);

    xact(2, 1'b1, 16'd100, 16'h1234, lat, rd, er, bz);
    check_eq("wr_lat",   32'(lat), 32'd2);
    check_eq("wr_rhold", 32'(rd),  32'h00AB);
    xact(2, 1'b0, 16'd100, 16'h0000, lat, rd, er, bz);
    check_eq("wr_rd_data", 32'(rd), 32'h1234);

`ifdef SHARED_DRAM_ADDR_CHECK_EN
    xact(0, 1'b1, 16'd0, 16'hC0DE, lat, rd, er, bz);
    check_eq("in_wr_err", 32'(er), 32'd0);
    xact(3, 1'b1, 16'd1024, 16'hBEEF, lat, rd, er, bz);
    check_eq("oor_wr_err",   32'(er), 32'd1);
    check_eq("oor_wr_rhold", 32'(rd), 32'h1234);
    xact(3, 1'b0, 16'd1024, 16'h0000, lat, rd, er, bz);
    check_eq("oor_rd_err",  32'(er), 32'd1);
    check_eq("oor_rd_data", 32'(rd), 32'h0000);
    xact(0, 1'b0, 16'd0, 16'h0000, lat, rd, er, bz);
    check_eq("ram0_keep", 32'(rd), 32'hC0DE);
    check_eq("ram0_err",  32'(er), 32'd0);
`else
    xact(3, 1'b1, 16'd1031, 16'h5A5A, lat, rd, er, bz);
    check_eq("alias_wr_err", 32'(er), 32'd0);
    xact(0, 1'b0, 16'd7, 16'h0000, lat, rd, er, bz);
    check_eq("alias_rd7", 32'(rd), 32'h5A5A);
    xact(1, 1'b0, 16'd1031, 16'h0000, lat, rd, er, bz);
    check_eq("alias_rd1031", 32'(rd), 32'h5A5A);
    check_eq("alias_err",    32'(er), 32'd0);
`endif

    @(negedge clk);
    bus.we[0]      = 1'b0;
    bus.addr[15:0] = 16'd100;
    bus.req[0]     = 1'b1;
    @(negedge clk);
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_ack",   32'(bus.ack),   32'd0);
    check_eq("mid_busyr", 32'(bus.busy),  32'd0);
    check_eq("mid_rdata", 32'(bus.rdata), 32'd0);
    check_eq("mid_err",   32'(bus.err),   32'd0);
    @(negedge clk);
    check_eq("mid_noack", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.ack[0]) begin
        lat = c;
        rd  = bus.rdata;
      end
    end
    bus.req[0] = 1'b0;
    check_eq("post_rst_lat",  32'(lat), 32'd2);
    check_eq("post_rst_data", 32'(rd),  32'h1234);

    do_reset();
    bus.we = '0;
    bus.addr = {16'd100, 16'd7, 16'd100, 16'd5};
    for (int r = 0; r < 2; r++) begin
      run_round(4'hF, 4'h0, 4, 20);
      check_eq("cont_n", 32'(got_n), 32'd4);
      for (int i = 0; i < 4; i++) begin
        check_eq("cont_core", 32'(got_core[i]), 32'(i));
        check_eq("cont_cyc",  32'(got_cyc[i]),  32'(2 + 3*i));
      end
      @(negedge clk);
    end

    do_reset();
    run_round(4'b1010, 4'b0010, 3, 20);
    check_eq("fair_n", 32'(got_n), 32'd3);
    check_eq("fair_c0", 32'(got_core[0]), 32'd1);
    check_eq("fair_c1", 32'(got_core[1]), 32'd3);
    check_eq("fair_c2", 32'(got_core[2]), 32'd1);
    check_eq("fair_t1", 32'(got_cyc[1]),  32'd5);
    check_eq("fair_t2", 32'(got_cyc[2]),  32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
